umi_xbar_sched: RTL and testbench

Packet-aware scheduler for the UMI NxN crossbar. It decodes each input's destination port into a per-output request. It runs one arbiter per output, either fixed-priority or round-robin, and locks each output to its owner until the end-of-message beat. The grants and ready/valid signals it produces drive the crossbar mux selects and handshakes directly, so multi-beat transactions are never interleaved on an output.

---
 rtl/umi_xbar_sched.sv | 133 +++++++++++++
 tb/tb_umi_xbar_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/umi_xbar_sched.sv
// Per-output packet-aware arbiter for the UMI NxN crossbar: decodes destinations,
// arbitrates (fixed priority or round-robin) and holds each output until end-of-message.
module umi_xbar_sched #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            mode,
  input  logic [N*N-1:0]  mask,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*PW-1:0] umi_in_dst,
  input  logic [N-1:0]    umi_in_eom,
  output logic [N-1:0]    umi_in_ready,
  input  logic [N-1:0]    umi_out_ready,
  output logic [N-1:0]    umi_out_valid,
  output logic [N*N-1:0]  grants,
  output logic [N-1:0]    locked,
  output logic [N-1:0]    err_dst
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

  state_t        r_state [N];
  logic [IW-1:0] r_owner [N];
  logic [IW-1:0] r_ptr   [N];

  state_t        w_state_nxt [N];
  logic [IW-1:0] w_owner_nxt [N];
  logic [IW-1:0] w_ptr_nxt   [N];
  logic [IW-1:0] w_gidx      [N];
  logic [N-1:0]  w_ghit;
  logic [N*N-1:0] w_req;
  logic [N-1:0]  w_xfer;

  // Request decode and destination range check
  always_comb begin
    w_req   = '0;
    err_dst = '0;
    for (int i = 0; i < N; i++) begin
      err_dst[i] = umi_in_valid[i] & (32'(umi_in_dst[i*PW +: PW]) >= 32'(N));
      for (int o = 0; o < N; o++) begin
        w_req[o*N+i] = umi_in_valid[i] & (32'(umi_in_dst[i*PW +: PW]) == 32'(o)) & ~mask[o*N+i];
      end
    end
  end

  // Per-output winner selection; a locked output always selects its owner
  always_comb begin
    for (int o = 0; o < N; o++) begin
      w_gidx[o] = '0;
      w_ghit[o] = 1'b0;
      if (r_state[o] == S_LOCK) begin
        w_gidx[o] = r_owner[o];
        w_ghit[o] = 1'b1;
      end else if (mode) begin
        for (int k = 0; k < N; k++) begin
          if (!w_ghit[o] && w_req[o*N + ((int'(r_ptr[o]) + k) % N)]) begin
            w_ghit[o] = 1'b1;
            w_gidx[o] = IW'((int'(r_ptr[o]) + k) % N);
          end
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (!w_ghit[o] && w_req[o*N+i]) begin
            w_ghit[o] = 1'b1;
            w_gidx[o] = IW'(i);
          end
        end
      end
    end
  end

  // Grant, handshake and lock status outputs, all forced low during reset
  always_comb begin
    grants        = '0;
    umi_out_valid = '0;
    umi_in_ready  = '0;
    locked        = '0;
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++) begin
        grants[o*N+i] = nreset & w_ghit[o] & (w_gidx[o] == IW'(i));
      end
      umi_out_valid[o] = |(grants[o*N +: N] & umi_in_valid);
      locked[o]        = nreset & (r_state[o] == S_LOCK);
    end
    for (int i = 0; i < N; i++) begin
      for (int o = 0; o < N; o++) begin
        umi_in_ready[i] = umi_in_ready[i] | (grants[o*N+i] & umi_out_ready[o]);
      end
    end
    w_xfer = umi_out_valid & umi_out_ready;
  end

  // Next-state: lock on a non-final beat, release and advance pointer on eom
  always_comb begin
    for (int o = 0; o < N; o++) begin
      w_state_nxt[o] = r_state[o];
      w_owner_nxt[o] = r_owner[o];
      w_ptr_nxt[o]   = r_ptr[o];
      if (w_xfer[o]) begin
        if (umi_in_eom[w_gidx[o]]) begin
          w_state_nxt[o] = S_IDLE;
          w_ptr_nxt[o]   = (32'(w_gidx[o]) == 32'(N-1)) ? '0 : w_gidx[o] + IW'(1);
        end else begin
          w_state_nxt[o] = S_LOCK;
          w_owner_nxt[o] = w_gidx[o];
        end
      end else begin
        w_state_nxt[o] = r_state[o];
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int o = 0; o < N; o++) begin
        r_state[o] <= S_IDLE;
        r_owner[o] <= '0;
        r_ptr[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < N; o++) begin
        r_state[o] <= w_state_nxt[o];
        r_owner[o] <= w_owner_nxt[o];
        r_ptr[o]   <= w_ptr_nxt[o];
      end
    end
  end

endmodule

// File: tb/tb_umi_xbar_sched.sv
// Bench for umi_xbar_sched: vector table, hand-written packet corner cases and a
// randomized run against a packet-level reference model.
module tb_umi_xbar_sched;
  localparam int N  = 4;
  localparam int PW = 3;

  logic        clk = 1'b0;
  logic        nreset;
  logic        mode;
  logic [15:0] mask;
  logic [3:0]  umi_in_valid;
  logic [11:0] umi_in_dst;
  logic [3:0]  umi_in_eom;
  logic [3:0]  umi_in_ready;
  logic [3:0]  umi_out_ready;
  logic [3:0]  umi_out_valid;
  logic [15:0] grants;
  logic [3:0]  locked;
  logic [3:0]  err_dst;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        md;
    logic [3:0]  v;
    logic [11:0] d;
    logic [3:0]  e;
    logic [3:0]  ordy;
    logic [3:0]  xg3;
    logic [3:0]  xrdy;
  } vec_t;
  vec_t tbl [6];

  int   m_lock [N];
  int   m_owner [N];
  int   m_ptr [N];
  int   g [N];
  bit   has [N];
  logic [15:0] eg;
  logic [3:0]  ev, er, ee, el;

  always #5 clk = ~clk;

  umi_xbar_sched #(.N(N), .PW(PW)) dut (
    .clk(clk), .nreset(nreset), .mode(mode), .mask(mask),
    .umi_in_valid(umi_in_valid), .umi_in_dst(umi_in_dst), .umi_in_eom(umi_in_eom),
    .umi_in_ready(umi_in_ready), .umi_out_ready(umi_out_ready),
    .umi_out_valid(umi_out_valid), .grants(grants), .locked(locked), .err_dst(err_dst)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic md, input logic [15:0] msk, input logic [3:0] v,
                       input logic [11:0] d, input logic [3:0] e, input logic [3:0] ordy);
    mode = md; mask = msk; umi_in_valid = v; umi_in_dst = d; umi_in_eom = e;
    umi_out_ready = ordy;
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 12'h0, 4'h0, 4'h0);
    repeat (2) tick();
    nreset = 1'b1;
    tick();
  endtask

  initial begin
    // mode 1 round robin rotation, then mode 0 fixed priority
    tbl[0] = '{1'b1, 4'b0111, 12'h0DB, 4'b1111, 4'b1000, 4'b0001, 4'b0001};
    tbl[1] = '{1'b1, 4'b0111, 12'h0DB, 4'b1111, 4'b1000, 4'b0010, 4'b0010};
    tbl[2] = '{1'b1, 4'b0111, 12'h0DB, 4'b1111, 4'b1000, 4'b0100, 4'b0100};
    tbl[3] = '{1'b1, 4'b0111, 12'h0DB, 4'b1111, 4'b1000, 4'b0001, 4'b0001};
    tbl[4] = '{1'b0, 4'b0111, 12'h0DB, 4'b1111, 4'b1000, 4'b0001, 4'b0001};
    tbl[5] = '{1'b0, 4'b0111, 12'h0DB, 4'b1111, 4'b1000, 4'b0001, 4'b0001};

    do_reset();
    check("reset_grants", 32'(grants), 32'h0);
    check("reset_locked", 32'(locked), 32'h0);
    check("reset_ready", 32'(umi_in_ready), 32'h0);

    for (int t = 0; t < 6; t++) begin
      drive(tbl[t].md, 16'h0, tbl[t].v, tbl[t].d, tbl[t].e, tbl[t].ordy);
      check($sformatf("tbl%0d_grant3", t), 32'(grants[15:12]), 32'(tbl[t].xg3));
      check($sformatf("tbl%0d_ready", t), 32'(umi_in_ready), 32'(tbl[t].xrdy));
      tick();
    end

    // 3-beat packet from input 1 to output 2, input 0 contends from beat 2
    do_reset();
    drive(1'b0, 16'h0, 4'b0010, 12'h012, 4'b0000, 4'b0100);
    check("pkt_b1_grant", 32'(grants[11:8]), 32'h2);
    check("pkt_b1_locked", 32'(locked), 32'h0);
    tick();
    drive(1'b0, 16'h0, 4'b0011, 12'h012, 4'b0000, 4'b0100);
    check("pkt_b2_grant", 32'(grants[11:8]), 32'h2);
    check("pkt_b2_locked", 32'(locked), 32'h4);
    check("pkt_b2_ready", 32'(umi_in_ready), 32'h2);
    tick();
    drive(1'b0, 16'h0, 4'b0011, 12'h012, 4'b0010, 4'b0100);
    check("pkt_b3_grant", 32'(grants[11:8]), 32'h2);
    check("pkt_b3_locked", 32'(locked), 32'h4);
    tick();
    drive(1'b0, 16'h0, 4'b0001, 12'h012, 4'b0000, 4'b0100);
    check("pkt_after_grant", 32'(grants[11:8]), 32'h1);
    check("pkt_after_locked", 32'(locked), 32'h0);
    check("pkt_after_ready", 32'(umi_in_ready), 32'h1);

    // owner bubbles for two cycles mid-packet
    do_reset();
    drive(1'b0, 16'h0, 4'b0010, 12'h012, 4'b0000, 4'b0100);
    tick();
    for (int b = 0; b < 2; b++) begin
      drive(1'b0, 16'h0, 4'b0001, 12'h012, 4'b0000, 4'b0100);
      check("bub_valid", 32'(umi_out_valid), 32'h0);
      check("bub_grant", 32'(grants[11:8]), 32'h2);
      check("bub_locked", 32'(locked), 32'h4);
      tick();
    end
    drive(1'b0, 16'h0, 4'b0011, 12'h012, 4'b0010, 4'b0100);
    check("bub_resume_valid", 32'(umi_out_valid), 32'h4);
    check("bub_resume_grant", 32'(grants[11:8]), 32'h2);
    tick();
    drive(1'b0, 16'h0, 4'b0001, 12'h012, 4'b0000, 4'b0100);
    check("bub_next_grant", 32'(grants[11:8]), 32'h1);

    // path mask blocks, clearing it grants in the same cycle
    do_reset();
    drive(1'b0, 16'h0200, 4'b0010, 12'h012, 4'b0010, 4'b0100);
    check("mask_grant", 32'(grants), 32'h0);
    check("mask_ready", 32'(umi_in_ready), 32'h0);
    drive(1'b0, 16'h0000, 4'b0010, 12'h012, 4'b0010, 4'b0100);
    check("unmask_grant", 32'(grants[11:8]), 32'h2);
    check("unmask_ready", 32'(umi_in_ready), 32'h2);

    // out-of-range destination
    drive(1'b0, 16'h0, 4'b1000, 12'hA00, 4'b1000, 4'b1111);
    check("err_dst", 32'(err_dst), 32'h8);
    check("err_ready", 32'(umi_in_ready), 32'h0);
    check("err_grant", 32'(grants), 32'h0);
    tick();

    // reset pulsed mid-packet
    do_reset();
    drive(1'b0, 16'h0, 4'b0010, 12'h012, 4'b0000, 4'b0100);
    tick();
    check("rst_pre_locked", 32'(locked), 32'h4);
    nreset = 1'b0;
    drive(1'b0, 16'h0, 4'b1010, 12'hA12, 4'b0000, 4'b1111);
    check("rst_grants", 32'(grants), 32'h0);
    check("rst_out_valid", 32'(umi_out_valid), 32'h0);
    check("rst_ready", 32'(umi_in_ready), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_err_dst", 32'(err_dst), 32'h8);
    tick();
    nreset = 1'b1;
    drive(1'b0, 16'h0, 4'b0000, 12'h012, 4'b0000, 4'b0100);
    check("rst_rel_locked", 32'(locked), 32'h0);
    check("rst_rel_grants", 32'(grants), 32'h0);
    drive(1'b0, 16'h0, 4'b0011, 12'h012, 4'b0010, 4'b0100);
    check("rst_rel_idle_grant", 32'(grants[11:8]), 32'h1);
    tick();

    // randomized run against the reference model
    do_reset();
    for (int o = 0; o < N; o++) begin
      m_lock[o] = 0; m_owner[o] = 0; m_ptr[o] = 0;
    end
    mode = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      logic [11:0] d;
      logic [15:0] msk;
      d = '0;
      for (int i = 0; i < N; i++) begin
        d[i*PW +: PW] = ($urandom_range(0, 9) > 8) ? PW'($urandom_range(4, 5)) : PW'($urandom_range(0, 3));
      end
      msk = ($urandom_range(0, 7) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
      drive(($urandom_range(0, 19) == 0) ? ~mode : mode, msk, 4'($urandom),
            d, 4'($urandom), 4'($urandom));

      eg = '0; ev = '0; er = '0; ee = '0; el = '0;
      for (int i = 0; i < N; i++) begin
        ee[i] = umi_in_valid[i] && (int'(umi_in_dst[i*PW +: PW]) >= N);
      end
      for (int o = 0; o < N; o++) begin
        has[o] = 1'b0; g[o] = 0;
        el[o] = (m_lock[o] != 0);
        if (m_lock[o] != 0) begin
          has[o] = 1'b1; g[o] = m_owner[o];
        end else begin
          for (int k = 0; k < N; k++) begin
            int cand;
            cand = mode ? (m_ptr[o] + k) % N : k;
            if (!has[o] && umi_in_valid[cand] && int'(umi_in_dst[cand*PW +: PW]) == o
                && !mask[o*N+cand]) begin
              has[o] = 1'b1; g[o] = cand;
            end
          end
        end
        if (has[o]) begin
          eg[o*N+g[o]] = 1'b1;
          ev[o] = umi_in_valid[g[o]];
          er[g[o]] = er[g[o]] | umi_out_ready[o];
        end
      end
      check("rnd_grants", 32'(grants), 32'(eg));
      check("rnd_out_valid", 32'(umi_out_valid), 32'(ev));
      check("rnd_in_ready", 32'(umi_in_ready), 32'(er));
      check("rnd_err_dst", 32'(err_dst), 32'(ee));
      check("rnd_locked", 32'(locked), 32'(el));

      for (int o = 0; o < N; o++) begin
        if (ev[o] && umi_out_ready[o]) begin
          if (umi_in_eom[g[o]]) begin
            m_lock[o] = 0; m_ptr[o] = (g[o] + 1) % N;
          end else begin
            m_lock[o] = 1; m_owner[o] = g[o];
          end
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
